// File: rtl/calc_entry_ctrl_pkg.sv
// Shared definitions for the calculator entry controller: operator codes,
// sequencing states and default sizing.
package calc_entry_ctrl_pkg;

    localparam int unsigned CALC_WIDTH      = 32;
    localparam int unsigned CALC_MAX_DIGITS = 9;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } calc_op_t;

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_OP   = 3'd1,
        S_B    = 3'd2,
        S_EXEC = 3'd3,
        S_RES  = 3'd4,
        S_ERR  = 3'd5
    } calc_state_t;

endpackage

// File: rtl/calc_entry_ctrl_digit_accum.sv
// Decimal operand accumulator: acc <= acc*10 + digit, leading zeros dropped,
// saturating silently once MAX_DIGITS significant digits are held.
module digit_accum #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MAX_DIGITS = 9
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              clear,
    input  logic                              load,
    input  logic [WIDTH-1:0]                  load_val,
    input  logic [$clog2(MAX_DIGITS+1)-1:0]   load_cnt,
    input  logic                              push,
    input  logic [3:0]                        digit,
    output logic [WIDTH-1:0]                  acc,
    output logic [WIDTH-1:0]                  acc_nxt
);

    localparam int unsigned CW = $clog2(MAX_DIGITS + 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    // acc_nxt is exported so the parent can register its display without lag.
    always_comb begin
        acc_nxt = acc;
        cnt_nxt = cnt;
        if (clear) begin
            acc_nxt = '0;
            cnt_nxt = '0;
        end else if (load) begin
            acc_nxt = load_val;
            cnt_nxt = load_cnt;
        end else if (push && digit <= 4'd9 && cnt != CW'(MAX_DIGITS)
                     && !(cnt == '0 && digit == 4'd0)) begin
            acc_nxt = acc * WIDTH'(10) + WIDTH'(digit);
            cnt_nxt = cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else begin
            acc <= acc_nxt;
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/calc_entry_ctrl.sv
// Calculator expression sequencer: keypad events to operands A/B, ALU
// start/done handshake, and registered display/status outputs.
module calc_entry_ctrl
    import calc_entry_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH      = CALC_WIDTH,
    parameter int unsigned MAX_DIGITS = CALC_MAX_DIGITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             digit_vld,
    input  logic [3:0]       digit,
    input  logic             op_vld,
    input  logic [1:0]       op_code,
    input  logic             eq_vld,
    input  logic             clr_vld,
    output logic             alu_start,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_op,
    input  logic             alu_done,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_err,
    output logic [WIDTH-1:0] disp_value,
    output logic             disp_err,
    output logic             busy
);

    localparam int unsigned CW = $clog2(MAX_DIGITS + 1);

    calc_state_t      state;
    logic [WIDTH-1:0] result;
    logic             ev_clr, ev_eq, ev_op, ev_dig;
    logic             a_clear, a_load, a_push;
    logic             b_clear, b_load, b_push;
    logic [WIDTH-1:0] a_load_val, a_acc, a_nxt, b_acc, b_nxt, d_val;
    logic [CW-1:0]    a_load_cnt, d_cnt;

    always_comb begin
        ev_clr = clr_vld;
        ev_eq  = eq_vld && !clr_vld;
        ev_op  = op_vld && !clr_vld && !eq_vld;
        ev_dig = digit_vld && !clr_vld && !eq_vld && !op_vld && digit <= 4'd9;
        d_val  = WIDTH'(digit);
        d_cnt  = CW'(digit != 4'd0);

        a_clear    = ev_clr;
        a_load     = 1'b0;
        a_load_val = d_val;
        a_load_cnt = d_cnt;
        a_push     = ev_dig && state == S_A;
        b_clear    = ev_clr || (ev_dig && state == S_RES);
        b_load     = ev_dig && state == S_OP;
        b_push     = ev_dig && state == S_B;
        // From a shown result, op/eq chain on it with no room for more digits.
        if (state == S_RES && !ev_clr) begin
            if (ev_eq || ev_op) begin
                a_load     = 1'b1;
                a_load_val = result;
                a_load_cnt = CW'(MAX_DIGITS);
            end else if (ev_dig) begin
                a_load = 1'b1;
            end
        end
    end

    digit_accum #(.WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS)) u_acc_a (
        .clk(clk), .rst_n(rst_n), .clear(a_clear), .load(a_load),
        .load_val(a_load_val), .load_cnt(a_load_cnt), .push(a_push),
        .digit(digit), .acc(a_acc), .acc_nxt(a_nxt)
    );

    digit_accum #(.WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS)) u_acc_b (
        .clk(clk), .rst_n(rst_n), .clear(b_clear), .load(b_load),
        .load_val(d_val), .load_cnt(d_cnt), .push(b_push),
        .digit(digit), .acc(b_acc), .acc_nxt(b_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_A;
            result     <= '0;
            alu_start  <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            disp_value <= '0;
            disp_err   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            alu_start <= 1'b0;
            if (ev_clr) begin
                state      <= S_A;
                result     <= '0;
                alu_a      <= '0;
                alu_b      <= '0;
                alu_op     <= '0;
                disp_value <= '0;
                disp_err   <= 1'b0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    S_A: begin
                        disp_value <= a_nxt;
                        if (ev_op) begin
                            alu_op <= op_code;
                            state  <= S_OP;
                        end
                    end
                    S_OP: begin
                        if (ev_op) begin
                            alu_op <= op_code;
                        end else if (ev_dig && !ev_eq) begin
                            state      <= S_B;
                            disp_value <= b_nxt;
                        end
                    end
                    S_B: begin
                        if (ev_eq) begin
                            state      <= S_EXEC;
                            alu_start  <= 1'b1;
                            alu_a      <= a_acc;
                            alu_b      <= b_acc;
                            busy       <= 1'b1;
                            disp_value <= a_acc;
                        end else begin
                            disp_value <= b_nxt;
                        end
                    end
                    S_EXEC: begin
                        if (alu_done) begin
                            busy <= 1'b0;
                            if (alu_err) begin
                                state      <= S_ERR;
                                disp_value <= '0;
                                disp_err   <= 1'b1;
                            end else begin
                                state      <= S_RES;
                                result     <= alu_result;
                                disp_value <= alu_result;
                            end
                        end
                    end
                    S_RES: begin
                        if (ev_eq) begin
                            state      <= S_EXEC;
                            alu_start  <= 1'b1;
                            alu_a      <= result;
                            alu_b      <= b_acc;
                            busy       <= 1'b1;
                            disp_value <= result;
                        end else if (ev_op) begin
                            state      <= S_OP;
                            alu_op     <= op_code;
                            disp_value <= result;
                        end else if (ev_dig) begin
                            state      <= S_A;
                            disp_value <= a_nxt;
                        end
                    end
                    S_ERR: ;
                    default: state <= S_A;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Randomized bench for calc_entry_ctrl against an expression-level model with
// a behavioural ALU responding after a random latency.
module tb_calc_entry_ctrl;
    import calc_entry_ctrl_pkg::*;

    localparam int MAXD = 9;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        digit_vld = 1'b0, op_vld = 1'b0, eq_vld = 1'b0, clr_vld = 1'b0;
    logic [3:0]  digit = '0;
    logic [1:0]  op_code = '0;
    logic        alu_start, alu_done = 1'b0, alu_err = 1'b0;
    logic [31:0] alu_a, alu_b, alu_result = '0, disp_value;
    logic [1:0]  alu_op;
    logic        disp_err, busy;

    calc_entry_ctrl #(.WIDTH(32), .MAX_DIGITS(MAXD)) dut (
        .clk(clk), .rst_n(rst_n), .digit_vld(digit_vld), .digit(digit),
        .op_vld(op_vld), .op_code(op_code), .eq_vld(eq_vld), .clr_vld(clr_vld),
        .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_done(alu_done), .alu_result(alu_result), .alu_err(alu_err),
        .disp_value(disp_value), .disp_err(disp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef enum {ENTER_A, ENTER_OP, ENTER_B, RUNNING, SHOWING, FAILED} phase_t;

    int          n_chk = 0;
    int          n_err = 0;
    phase_t      phase;
    logic [31:0] ma, mb, mres, ea, eb;
    int          na, nb;
    logic [1:0]  mop;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        phase = ENTER_A;
        ma = '0; mb = '0; mres = '0; ea = '0; eb = '0;
        na = 0; nb = 0; mop = '0;
    endtask

    // Significant digits only; a full operand accepts nothing more.
    task automatic enter_digit(inout logic [31:0] v, inout int n, input int d);
        if (d <= 9 && n < MAXD && !(n == 0 && d == 0)) begin
            v = v * 10 + d;
            n++;
        end
    endtask

    task automatic alu_model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                             output logic [31:0] r, output logic e);
        logic [63:0] w;
        e = 1'b0;
        w = '0;
        case (calc_op_t'(op))
            OP_ADD: begin w = {32'd0, a} + {32'd0, b}; e = (w > 64'hFFFF_FFFF); end
            OP_SUB: begin w = {32'd0, a} - {32'd0, b}; e = (a < b); end
            OP_MUL: begin w = {32'd0, a} * {32'd0, b}; e = (w > 64'hFFFF_FFFF); end
            default: begin
                if (b == 0) e = 1'b1;
                else w = {32'd0, a / b};
            end
        endcase
        r = e ? $urandom : w[31:0];
    endtask

    // One clock: drive strobes, advance the model, compare every output.
    task automatic cyc(input bit c, input bit e, input bit o, input logic [1:0] oc,
                       input bit dv, input logic [3:0] d,
                       input bit dn, input logic [31:0] res, input bit er);
        bit          exp_start;
        logic [31:0] exp_disp;
        clr_vld = c; eq_vld = e; op_vld = o; op_code = oc; digit_vld = dv; digit = d;
        alu_done = dn; alu_result = res; alu_err = er;
        @(posedge clk);
        #1;
        clr_vld = 0; eq_vld = 0; op_vld = 0; digit_vld = 0; alu_done = 0; alu_err = 0;
        exp_start = 0;
        if (c) begin
            model_reset();
        end else begin
            case (phase)
                ENTER_A: if (!e) begin
                    if (o) begin mop = oc; phase = ENTER_OP; end
                    else if (dv) enter_digit(ma, na, int'(d));
                end
                ENTER_OP: if (!e) begin
                    if (o) mop = oc;
                    else if (dv && d <= 9) begin
                        mb = 32'(d); nb = (d != 0) ? 1 : 0; phase = ENTER_B;
                    end
                end
                ENTER_B: begin
                    if (e) begin ea = ma; eb = mb; phase = RUNNING; exp_start = 1; end
                    else if (!o && dv) enter_digit(mb, nb, int'(d));
                end
                RUNNING: if (dn) begin
                    if (er) phase = FAILED;
                    else begin mres = res; phase = SHOWING; end
                end
                SHOWING: begin
                    if (e) begin
                        ma = mres; na = MAXD; ea = ma; eb = mb; phase = RUNNING; exp_start = 1;
                    end else if (o) begin
                        ma = mres; na = MAXD; mop = oc; phase = ENTER_OP;
                    end else if (dv && d <= 9) begin
                        ma = 32'(d); na = (d != 0) ? 1 : 0; mb = 0; nb = 0; phase = ENTER_A;
                    end
                end
                default: ;
            endcase
        end
        case (phase)
            ENTER_B: exp_disp = mb;
            SHOWING: exp_disp = mres;
            FAILED:  exp_disp = 0;
            default: exp_disp = ma;
        endcase
        chk("disp_value", disp_value, exp_disp);
        chk("disp_err", 32'(disp_err), 32'(phase == FAILED));
        chk("busy", 32'(busy), 32'(phase == RUNNING));
        chk("alu_start", 32'(alu_start), 32'(exp_start));
        if (phase == RUNNING) begin
            chk("alu_a", alu_a, ea);
            chk("alu_b", alu_b, eb);
            chk("alu_op", 32'(alu_op), 32'(mop));
        end
        if (c) begin
            chk("clr_alu_a", alu_a, 0);
            chk("clr_alu_b", alu_b, 0);
            chk("clr_alu_op", 32'(alu_op), 0);
        end
    endtask

    task automatic idle();         cyc(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic key_d(input int d);  cyc(0, 0, 0, 0, 1, 4'(d), 0, 0, 0); endtask
    task automatic key_op(input int o); cyc(0, 0, 1, 2'(o), 0, 0, 0, 0, 0); endtask
    task automatic key_eq();       cyc(0, 1, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic key_clr();      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0); endtask

    // ALU answers from the expected operands; latency 0 means done alongside start.
    task automatic run_alu(input bit abort_ok);
        logic [31:0] r;
        logic        e;
        int          lat;
        alu_model(ea, eb, mop, r, e);
        lat = $urandom_range(0, 3);
        for (int i = 0; i < lat; i++) begin
            if (abort_ok && $urandom_range(0, 5) == 0) begin
                key_clr();
                break;
            end
            cyc(0, $urandom_range(0, 1) == 1, 0, 0, $urandom_range(0, 1) == 1, 4'd5, 0, 0, 0);
        end
        cyc(0, 0, 0, 0, 0, 0, 1, r, e);
    endtask

    initial begin
        model_reset();
        #1;
        chk("rst_disp", disp_value, 0);
        chk("rst_start", 32'(alu_start), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(disp_err), 0);
        chk("rst_alu_a", alu_a, 0);
        #11 rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle();

        // 123 + 45 = 168
        key_d(1); key_d(2); key_d(3); key_op(0); key_d(4); key_d(5); key_eq();
        chk("add_a", alu_a, 123);
        chk("add_b", alu_b, 45);
        chk("add_start", 32'(alu_start), 1);
        run_alu(0);
        chk("add_result", disp_value, 168);

        // Chain on the result, then repeat '='
        key_op(1); key_d(8); key_eq();
        chk("chain_a", alu_a, 168);
        chk("chain_b", alu_b, 8);
        chk("chain_op", 32'(alu_op), 1);
        run_alu(0);
        key_eq();
        chk("rerun_a", alu_a, 160);
        chk("rerun_b", alu_b, 8);
        run_alu(0);
        chk("rerun_res", disp_value, 152);

        // Leading zeros and digit saturation
        key_clr(); key_d(0); key_d(0); key_d(7);
        chk("lead_zero", disp_value, 7);
        key_clr();
        for (int i = 0; i < 10; i++) key_d(9);
        chk("saturate", disp_value, 999999999);
        key_d(15);

        // Divide by zero, error holds until clear
        key_clr(); key_d(8); key_op(3); key_d(0); key_eq();
        run_alu(0);
        chk("div0_err", 32'(disp_err), 1);
        chk("div0_disp", disp_value, 0);
        key_d(3); key_eq(); key_op(0);
        chk("err_hold", 32'(disp_err), 1);
        key_clr();
        chk("err_clr", 32'(disp_err), 0);

        // Simultaneous strobes: clear wins
        key_d(6); cyc(1, 0, 1, 2, 1, 4'd4, 0, 0, 0);
        chk("clr_wins", disp_value, 0);

        // Clear aborts EXEC; late done ignored
        key_d(5); key_op(0); key_d(3); key_eq();
        key_clr();
        cyc(0, 0, 0, 0, 0, 0, 1, 32'd8, 0);
        chk("abort_disp", disp_value, 0);
        chk("abort_busy", 32'(busy), 0);

        // Asynchronous reset mid-entry
        key_d(4); key_d(2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_disp", disp_value, 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_alu_op", 32'(alu_op), 0);
        #3 rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        idle();

        // Random keypad traffic
        for (int n = 0; n < 600; n++) begin
            int r;
            r = $urandom_range(0, 31);
            if (r == 0)       key_clr();
            else if (r < 4)   key_eq();
            else if (r < 8)   key_op($urandom_range(0, 3));
            else if (r < 12)  cyc($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
                                  $urandom_range(0, 1) == 1, 2'($urandom),
                                  $urandom_range(0, 1) == 1, 4'($urandom), 0, 0, 0);
            else if (r < 14)  key_d($urandom_range(10, 15));
            else if (r < 18)  key_d(0);
            else              key_d($urandom_range(0, 9));
            if (phase == RUNNING) run_alu(1);
            if (phase == FAILED && $urandom_range(0, 3) == 0) key_clr();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
